// File: rtl/hf14a_tag_decoder.sv
// ISO14443-A tag response decoder: SOF lock, Manchester bit decode,
// LSB-first byte assembly with parity, collision and end-of-frame flags.
`timescale 1ns/1ps

module hf14a_tag_decoder #(
  parameter int HALF_THRESH = 2
) (
  input  logic       ck_1356meg,
  input  logic       nrst,
  input  logic       enable,
  input  logic       sample_stb,
  input  logic       mod_bit,
  output logic [7:0] data_out,
  output logic       parity_out,
  output logic       coll_out,
  output logic       byte_valid,
  output logic       frame_end,
  output logic [2:0] last_bits,
  output logic [5:0] byte_count,
  output logic       sof_err
);

  typedef enum logic [1:0] {
    IDLE,
    SOF,
    DATA
  } state_t;

  state_t     state;
  logic [2:0] phase;
  logic [2:0] cnt1;
  logic [2:0] cnt2;
  logic [3:0] bit_idx;
  logic [7:0] shreg;
  logic       coll_flag;
  logic [5:0] byte_cnt;

  logic [2:0] c1_next;
  logic [2:0] c2_next;
  logic       h1;
  logic       h2;
  logic       last_ph;
  logic       decide;
  logic       is_one;
  logic       is_coll;
  logic       is_eof;
  logic       bit_val;

  // Half-bit counts including the current decision and the bit verdict.
  always_comb begin
    c1_next = cnt1 + {2'b00, mod_bit & ~phase[2]};
    c2_next = cnt2 + {2'b00, mod_bit & phase[2]};
    h1      = c1_next >= 3'(HALF_THRESH);
    h2      = c2_next >= 3'(HALF_THRESH);
    last_ph = phase == 3'd7;
    decide  = enable & sample_stb & last_ph
            & (state != IDLE);
    is_one  = h1 & ~h2;
    is_coll = h1 & h2;
    is_eof  = ~h1 & ~h2;
    bit_val = h1;
  end

  // Phase and per-half modulation counters, locked to the SOF sample.
  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      phase <= 3'd0;
      cnt1  <= 3'd0;
      cnt2  <= 3'd0;
    end else if (!enable) begin
      phase <= 3'd0;
      cnt1  <= 3'd0;
      cnt2  <= 3'd0;
    end else if (sample_stb) begin
      if (state == IDLE) begin
        phase <= mod_bit ? 3'd1 : 3'd0;
        cnt1  <= {2'b00, mod_bit};
        cnt2  <= 3'd0;
      end else if (last_ph) begin
        phase <= 3'd0;
        cnt1  <= 3'd0;
        cnt2  <= 3'd0;
      end else begin
        phase <= phase + 3'd1;
        cnt1  <= c1_next;
        cnt2  <= c2_next;
      end
    end
  end

  // Frame FSM: SOF check, byte assembly and registered strobes.
  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      bit_idx    <= 4'd0;
      shreg      <= 8'd0;
      coll_flag  <= 1'b0;
      byte_cnt   <= 6'd0;
      data_out   <= 8'd0;
      parity_out <= 1'b0;
      coll_out   <= 1'b0;
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      last_bits  <= 3'd0;
      byte_count <= 6'd0;
      sof_err    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      sof_err    <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        bit_idx   <= 4'd0;
        shreg     <= 8'd0;
        coll_flag <= 1'b0;
        byte_cnt  <= 6'd0;
      end else if (sample_stb) begin
        unique case (state)
          IDLE: begin
            if (mod_bit) state <= SOF;
          end
          SOF: begin
            if (decide) begin
              if (is_one) begin
                state     <= DATA;
                bit_idx   <= 4'd0;
                shreg     <= 8'd0;
                coll_flag <= 1'b0;
                byte_cnt  <= 6'd0;
              end else begin
                sof_err <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          DATA: begin
            if (decide) begin
              if (is_eof) begin
                // partial bits are already right-aligned in shreg
                frame_end  <= 1'b1;
                last_bits  <= bit_idx[2:0];
                byte_count <= byte_cnt;
                state      <= IDLE;
                if (bit_idx != 4'd0) begin
                  byte_valid <= 1'b1;
                  data_out   <= shreg;
                  parity_out <= 1'b0;
                  coll_out   <= coll_flag;
                end
              end else if (bit_idx == 4'd8) begin
                byte_valid <= 1'b1;
                data_out   <= shreg;
                parity_out <= bit_val;
                coll_out   <= coll_flag | is_coll;
                if (byte_cnt != 6'd63)
                  byte_cnt <= byte_cnt + 6'd1;
                bit_idx   <= 4'd0;
                shreg     <= 8'd0;
                coll_flag <= 1'b0;
              end else begin
                shreg[bit_idx[2:0]] <= bit_val;
                bit_idx   <= bit_idx + 4'd1;
                coll_flag <= coll_flag | is_coll;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
